// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory bus controller: FSM encodings,
// byte-enable patterns and lane-classification helpers.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  function automatic logic is_half(input logic [3:0] b);
    return (b == BE_HALF_LO) || (b == BE_HALF_HI);
  endfunction

  function automatic logic is_byte(input logic [3:0] b);
    return (b == BE_BYTE0) || (b == BE_BYTE1) || (b == BE_BYTE2) || (b == BE_BYTE3);
  endfunction

endpackage

// File: rtl/st_lane_rep.sv
// Store-data lane replication: copies the low half/byte of the store data
// onto every lane so the bus byte enables alone select what gets written.
module st_lane_rep
  import dm_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rep
);

  always_comb begin
    rep = wdata;
    if (is_half(be)) begin
      rep = {2{wdata[15:0]}};
    end else if (is_byte(be)) begin
      rep = {4{wdata[7:0]}};
    end
  end

endmodule

// File: rtl/dm_bus_ctrl.sv
// MEM-stage data-memory bus controller: runs one req/ack transaction per
// load/store, stalling the pipeline until ack or timeout.
module dm_bus_ctrl
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        err_flag;
  logic        stall_fsm;
  logic        access;
  logic        timeout_hit;
  logic [31:0] rep_wdata;

  assign access      = mem_rd | mem_wr;
  assign timeout_hit = (cnt == TO_LAST);

  st_lane_rep u_lane_rep (
    .be    (be),
    .wdata (wdata),
    .rep   (rep_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_fsm = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (access) begin
          stall_fsm = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_fsm = 1'b1;
        if (bus_ack || timeout_hit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stall is masked while reset is held so a pending MEM request cannot
  // freeze the pipeline during reset.
  assign stall   = rst_n & stall_fsm;
  assign bus_req = (state == ST_REQ);
  assign bus_err = (state == ST_DONE) & err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= mem_wr;
            bus_be    <= be;
            bus_wdata <= rep_wdata;
            cnt       <= '0;
            err_flag  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            if (!bus_we) begin
              rdata <= bus_rdata;
            end
          end else if (timeout_hit) begin
            rdata    <= '0;
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Scoreboard bench for dm_bus_ctrl: expected bus transactions are queued per
// access and compared when the controller raises bus_req.
module tb_dm_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  logic req_prev = 1'b0;

  dm_bus_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .stall     (stall),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_rep(input logic [3:0] b, input logic [31:0] d);
    case (b)
      4'b1111:                            return d;
      4'b0011, 4'b1100:                   return {d[15:0], d[15:0]};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      default:                            return d;
    endcase
  endfunction

  // Compare the issued bus transaction against the scoreboard at the start of REQ.
  always @(negedge clk) begin
    if (bus_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL sb_unexpected_req: bus_addr=%h with empty scoreboard", bus_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus_we !== e.we) begin
          errors++; $display("FAIL sb_we: got %b expected %b", bus_we, e.we);
        end
        checks++;
        if (bus_addr !== e.addr) begin
          errors++; $display("FAIL sb_addr: got %h expected %h", bus_addr, e.addr);
        end
        checks++;
        if (bus_be !== e.be) begin
          errors++; $display("FAIL sb_be: got %b expected %b", bus_be, e.be);
        end
        checks++;
        if (bus_wdata !== e.wdata) begin
          errors++; $display("FAIL sb_wdata: got %h expected %h", bus_wdata, e.wdata);
        end
      end
    end
    req_prev = bus_req;
  end

  // ack_after < 0 means never acknowledge; otherwise ack on REQ cycle ack_after+1.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input int ack_after,
                            input logic [31:0] rd_val, output int stall_n, output int req_n,
                            output logic [31:0] rd_seen, output logic err_seen);
    exp_t e;
    int   cyc;
    bit   done;
    e.we = wr; e.addr = {a[31:2], 2'b00}; e.be = b; e.wdata = model_rep(b, d);
    exp_q.push_back(e);
    stall_n = 0; req_n = 0; cyc = 0; done = 0; rd_seen = '0; err_seen = 1'b0;
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d; be = b;
    while (!done && cyc < 100) begin
      #1;
      if (stall) begin
        stall_n++;
        if (bus_req) begin
          req_n++;
          if (ack_after >= 0 && req_n == ack_after + 1) begin
            bus_ack = 1'b1; bus_rdata = rd_val;
          end else begin
            bus_ack = 1'b0; bus_rdata = 32'hBAD0_BAD0;
          end
        end
        @(negedge clk);
        cyc++;
      end else begin
        done = 1;
        rd_seen = rdata; err_seen = bus_err;
        mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL access_bound: stall still high after %0d cycles, required release", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_rd = 0; mem_wr = 0; addr = '0; wdata = '0; be = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, bus_req, bus_we, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {stall, bus_req, bus_we, bus_err});
    end
    checks++;
    if ({bus_addr, bus_be, bus_wdata, rdata} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h be=%b wdata=%h rdata=%h expected all 0",
                         bus_addr, bus_be, bus_wdata, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 32'h0, s, r, rd, er);
    checks++;
    if (s !== 2) begin errors++; $display("FAIL sw_stall: got %0d cycles expected 2", s); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", er); end
  endtask

  task automatic test_sb();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b0, 1'b1, 32'h103, 32'h000000A5, 4'b1000, 3, 32'h0, s, r, rd, er);
    checks++;
    if (s !== 5) begin errors++; $display("FAIL sb_stall: got %0d cycles expected 5", s); end
  endtask

  task automatic test_lw();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b1, 1'b0, 32'h204, 32'h0, 4'b1111, 1, 32'h12345678, s, r, rd, er);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL lw_rdata: got %h expected 12345678", rd); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
    checks++;
    if (s !== 3) begin errors++; $display("FAIL lw_stall: got %0d cycles expected 3", s); end
  endtask

  task automatic test_store_keeps_rdata();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b0, 1'b1, 32'h041, 32'h0000_0077, 4'b0010, 0, 32'hFFFF_FFFF, s, r, rd, er);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL st_rdata_kept: got %h expected 12345678", rd); end
  endtask

  task automatic test_timeout();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b1, 1'b0, 32'h206, 32'h0, 4'b1100, -1, 32'h0, s, r, rd, er);
    checks++;
    if (r !== 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", r); end
    checks++;
    if (s !== 17) begin errors++; $display("FAIL to_stall: got %0d expected 17", s); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0", rd); end
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", er); end
    @(negedge clk); #1;
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b expected 0", bus_err); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int s, r; logic [31:0] rd; logic er;
    e.we = 1'b1; e.addr = 32'h300; e.be = 4'b1111; e.wdata = 32'h5555AAAA;
    exp_q.push_back(e);
    @(negedge clk);
    mem_wr = 1'b1; addr = 32'h300; wdata = 32'h5555AAAA; be = 4'b1111;
    @(negedge clk); #1;
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_in_req: got %b expected 1", bus_req); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall} !== 2'b00) begin
      errors++; $display("FAIL rm_drop: req/stall got %b expected 00", {bus_req, stall});
    end
    checks++;
    if (bus_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", bus_addr); end
    @(negedge clk);
    mem_wr = 1'b0; rst_n = 1'b1;
    run_access(1'b1, 1'b0, 32'h308, 32'h0, 4'b1111, 0, 32'hCAFEF00D, s, r, rd, er);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rm_lw_rdata: got %h expected cafef00d", rd); end
    checks++;
    if (s !== 2) begin errors++; $display("FAIL rm_lw_stall: got %0d expected 2", s); end
  endtask

  task automatic test_both_high();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b1, 1'b1, 32'h2, 32'h0000BEEF, 4'b1100, 0, 32'h1111_2222, s, r, rd, er);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL both_rdata_kept: got %h expected cafef00d", rd); end
  endtask

  task automatic test_illegal_be();
    int s, r; logic [31:0] rd; logic er;
    run_access(1'b0, 1'b1, 32'h40C, 32'h11223344, 4'b0101, 0, 32'h0, s, r, rd, er);
    run_access(1'b0, 1'b1, 32'h410, 32'h99887766, 4'b0000, 2, 32'h0, s, r, rd, er);
    checks++;
    if (s !== 4) begin errors++; $display("FAIL illegal_stall: got %0d expected 4", s); end
  endtask

  task automatic test_ack_ignored();
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk); #1;
    checks++;
    if ({bus_req, stall, bus_err} !== 3'b000) begin
      errors++; $display("FAIL idle_ack: req/stall/err got %b expected 000", {bus_req, stall, bus_err});
    end
    checks++;
    if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL idle_ack_rdata: got %h expected cafef00d", rdata); end
    bus_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lw();
    test_store_keeps_rdata();
    test_timeout();
    test_reset_mid();
    test_both_high();
    test_illegal_be();
    test_ack_ignored();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d transactions never issued, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
